// File: rtl/accum_pkg.sv
// Shared FSM state encoding and default widths for the product accumulator.
package accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_PROD_W = 64;
  localparam int DEF_ACC_W  = 72;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/sat_add.sv
// Combinational saturating signed adder: clamps to the most positive or negative ACC_W value.
// Zero latency; no flow control.
module sat_add
  import accum_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] w_raw;
  logic             w_ovf_pos;
  logic             w_ovf_neg;

  assign w_raw = a + b;

  // Overflow only when both operands share a sign that the raw sum lost.
  assign w_ovf_pos = ~a[ACC_W-1] & ~b[ACC_W-1] &  w_raw[ACC_W-1];
  assign w_ovf_neg =  a[ACC_W-1] &  b[ACC_W-1] & ~w_raw[ACC_W-1];

  always_comb begin
    sum = w_raw;
    if (w_ovf_pos) begin
      sum = {1'b0, {(ACC_W-1){1'b1}}};
    end else if (w_ovf_neg) begin
      sum = {1'b1, {(ACC_W-1){1'b0}}};
    end
  end

  assign ovf = w_ovf_pos | w_ovf_neg;

endmodule

// File: rtl/product_accumulator.sv
// Sums len signed products with saturation; result valid the cycle after the last accepted product.
// p_ready is high only while accumulating; gaps in p_valid are absorbed without losing state.
module product_accumulator
  import accum_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] p,
  input  logic              p_valid,
  output logic              p_ready,
  output logic [ACC_W-1:0]  acc,
  output logic              acc_valid,
  output logic              busy,
  output logic              overflow
);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_acc_valid;
  logic             r_overflow;

  logic [ACC_W-1:0] w_p_ext;
  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;

  assign w_p_ext = ACC_W'($signed(p));

  sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a   (r_acc),
    .b   (w_p_ext),
    .sum (w_sum),
    .ovf (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_acc_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
            if (len == '0) begin
              r_acc_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_acc_valid <= 1'b0;
              r_count     <= len;
              r_state     <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (p_valid) begin
            r_acc   <= w_sum;
            r_count <= r_count - CNT_W'(1);
            if (w_ovf) begin
              r_overflow <= 1'b1;
            end
            if (r_count == CNT_W'(1)) begin
              r_acc_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign p_ready   = (r_state == ST_ACCUM);
  assign busy      = (r_state == ST_ACCUM);
  assign acc       = r_acc;
  assign acc_valid = r_acc_valid;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed-vector bench: default 72-bit accumulator plus a 64-bit instance for saturation cases.
module tb_product_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [63:0] p;
  logic        p_valid;

  logic        p_ready, acc_valid, busy, overflow;
  logic [71:0] acc;
  logic        p_ready64, acc_valid64, busy64, overflow64;
  logic [63:0] acc64;

  int checks   = 0;
  int failures = 0;

  product_accumulator u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .p         (p),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .acc       (acc),
    .acc_valid (acc_valid),
    .busy      (busy),
    .overflow  (overflow)
  );

  product_accumulator #(
    .PROD_W (64),
    .ACC_W  (64),
    .CNT_W  (8)
  ) u_dut64 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .p         (p),
    .p_valid   (p_valid),
    .p_ready   (p_ready64),
    .acc       (acc64),
    .acc_valid (acc_valid64),
    .busy      (busy64),
    .overflow  (overflow64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [63:0] v);
    p       = v;
    p_valid = 1'b1;
    tick();
    p_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; len = 8'd3; p = '0; p_valid = 1'b0;
    tick();
    tick();
    // reset wins over a simultaneous start
    check_val("rst_busy",      72'(busy),      72'd0);
    check_val("rst_p_ready",   72'(p_ready),   72'd0);
    check_val("rst_acc",       acc,            72'd0);
    check_val("rst_acc_valid", 72'(acc_valid), 72'd0);
    check_val("rst_overflow",  72'(overflow),  72'd0);
    rst = 1'b0; start = 1'b0;
    tick();

    // basic sum of three products
    do_start(8'd3);
    check_val("s1_busy",    72'(busy),    72'd1);
    check_val("s1_p_ready", 72'(p_ready), 72'd1);
    push(64'd1500);
    push(64'd2064);
    check_val("s1_valid_early", 72'(acc_valid), 72'd0);
    push(64'(-345));
    check_val("s1_acc",       acc,            72'd3219);
    check_val("s1_acc_valid", 72'(acc_valid), 72'd1);
    check_val("s1_overflow",  72'(overflow),  72'd0);
    check_val("s1_busy_done", 72'(busy),      72'd0);
    push(64'd99);
    check_val("s1_done_ignores_p", acc, 72'd3219);
    tick();
    check_val("s1_done_hold", 72'(acc_valid), 72'd1);

    // zero-length request
    do_start(8'd0);
    check_val("s2_acc_valid", 72'(acc_valid), 72'd1);
    check_val("s2_acc",       acc,            72'd0);
    check_val("s2_busy",      72'(busy),      72'd0);
    check_val("s2_p_ready",   72'(p_ready),   72'd0);

    // gaps between products
    do_start(8'd2);
    push(64'(-750));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("s3_gap_valid", 72'(acc_valid), 72'd0);
      check_val("s3_gap_acc",   acc,            72'(-750));
    end
    push(64'(-2250));
    check_val("s3_acc",       acc,            72'(-3000));
    check_val("s3_acc_valid", 72'(acc_valid), 72'd1);

    // start mid-accumulation is ignored
    do_start(8'd4);
    push(64'd10);
    push(64'd10);
    do_start(8'd7);
    check_val("s4_busy_after_restart", 72'(busy), 72'd1);
    check_val("s4_acc_after_restart",  acc,       72'd20);
    push(64'd2500);
    push(64'd0);
    check_val("s4_acc",       acc,            72'd2520);
    check_val("s4_acc_valid", 72'(acc_valid), 72'd1);

    // positive saturation on the 64-bit instance
    do_start(8'd2);
    push(64'h4000_0000_0000_0000);
    check_val("s5_acc64_first", 72'(acc64),      72'h4000_0000_0000_0000);
    check_val("s5_ovf64_first", 72'(overflow64), 72'd0);
    push(64'h4000_0000_0000_0000);
    check_val("s5_acc64_sat", 72'(acc64),      72'h7FFF_FFFF_FFFF_FFFF);
    check_val("s5_ovf64_sat", 72'(overflow64), 72'd1);
    check_val("s5_acc72_wide", acc,            72'h0_8000_0000_0000_0000);
    check_val("s5_ovf72_wide", 72'(overflow),  72'd0);
    do_start(8'd3);
    check_val("s5_ovf64_clear", 72'(overflow64), 72'd0);

    // negative saturation, then continue from the clamp
    push(64'h8000_0000_0000_0000);
    check_val("s5_neg_first", 72'(overflow64), 72'd0);
    push(64'hFFFF_FFFF_FFFF_FFFF);
    check_val("s5_neg_sat",     72'(acc64),      72'h8000_0000_0000_0000);
    check_val("s5_neg_ovf",     72'(overflow64), 72'd1);
    push(64'd5);
    check_val("s5_after_sat",   72'(acc64),      72'h8000_0000_0000_0005);
    check_val("s5_ovf_sticky",  72'(overflow64), 72'd1);

    // reset in the middle of an accumulation
    do_start(8'd3);
    push(64'd7);
    check_val("s6_partial", acc, 72'd7);
    rst = 1'b1; p = 64'd9; p_valid = 1'b1;
    tick();
    rst = 1'b0; p_valid = 1'b0;
    check_val("s6_acc",       acc,            72'd0);
    check_val("s6_acc_valid", 72'(acc_valid), 72'd0);
    check_val("s6_p_ready",   72'(p_ready),   72'd0);
    do_start(8'd1);
    push(64'd20);
    check_val("s6_acc_new",   acc,            72'd20);
    check_val("s6_valid_new", 72'(acc_valid), 72'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
